// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: bus widths, RAM port width, FSM states and mem_len codes.
package mem_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned RAM_DW = 8;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IF_RD  = 2'b01,
      MEM_RD = 2'b10,
      MEM_WR = 2'b11
   } state_e;

   // Index of the last byte moved for a given mem_len code (1x means a full word).
   function automatic logic [1:0] last_idx(input logic [1:0] len);
      case (len)
         LEN_BYTE: last_idx = 2'd0;
         LEN_HALF: last_idx = 2'd1;
         default:  last_idx = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_bytepack.sv
// Little-endian lane insert plus load extension for mem_ctrl.
// Sign extension is compiled in only when MEMCTRL_SEXT_EN is defined.
module mem_ctrl_bytepack
   import mem_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        lane_i,
   input  logic [RAM_DW-1:0] byte_i,
   input  logic [1:0]        len_i,
   input  logic              signed_i,
   output logic [DATA_W-1:0] ins_o,
   output logic [DATA_W-1:0] ext_o
);

   logic sext_b;
   logic sext_h;

`ifdef MEMCTRL_SEXT_EN
   assign sext_b = signed_i & ins_o[7];
   assign sext_h = signed_i & ins_o[15];
`else
   logic unused_signed;
   assign unused_signed = signed_i;
   assign sext_b        = 1'b0;
   assign sext_h        = 1'b0;
`endif

   always_comb begin
      ins_o = word_i;
      ins_o[{lane_i, 3'b000} +: RAM_DW] = byte_i;
   end

   always_comb begin
      case (len_i)
         LEN_BYTE: ext_o = {{24{sext_b}}, ins_o[7:0]};
         LEN_HALF: ext_o = {{16{sext_h}}, ins_o[15:0]};
         default:  ext_o = ins_o;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store onto an 8-bit RAM.
// Build option MEMCTRL_SEXT_EN enables sign extension of signed byte/halfword loads.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_len,
   input  logic              mem_signed,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] ram_a,
   output logic [RAM_DW-1:0] ram_dout,
   output logic              ram_wr,
   input  logic [RAM_DW-1:0] ram_din,
   output logic              stallreq_if,
   output logic              stallreq_mem
);

   state_e            state_q;
   logic [2:0]        cnt_q;
   logic [1:0]        last_q;
   logic [1:0]        len_q;
   logic              sgn_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] buf_q;
   logic [ADDR_W-1:0] ram_a_q;
   logic [RAM_DW-1:0] ram_dout_q;
   logic              ram_wr_q;
   logic              if_done_q;
   logic              mem_done_q;
   logic [DATA_W-1:0] if_inst_q;
   logic [DATA_W-1:0] mem_rdata_q;

   logic [1:0]        lane_d;
   logic [1:0]        wr_idx_d;
   logic [DATA_W-1:0] ins_d;
   logic [DATA_W-1:0] ext_d;

   // Read data lags the address by one cycle, so the byte landing now belongs to lane cnt-1.
   assign lane_d   = cnt_q[1:0] - 2'd1;
   assign wr_idx_d = cnt_q[1:0] + 2'd1;

   mem_ctrl_bytepack u_bytepack (
      .word_i   (buf_q),
      .lane_i   (lane_d),
      .byte_i   (ram_din),
      .len_i    (len_q),
      .signed_i (sgn_q),
      .ins_o    (ins_d),
      .ext_o    (ext_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= '0;
         len_q       <= '0;
         sgn_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         buf_q       <= '0;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // The done cycle still sees the finished requester's req high; do not re-grant it.
               if (!if_done_q && !mem_done_q) begin
                  cnt_q <= '0;
                  buf_q <= '0;
                  if (mem_req) begin
                     addr_q  <= mem_addr;
                     last_q  <= last_idx(mem_len);
                     len_q   <= mem_len;
                     sgn_q   <= mem_signed;
                     wdata_q <= mem_wdata;
                     ram_a_q <= mem_addr;
                     if (mem_we) begin
                        state_q    <= MEM_WR;
                        ram_wr_q   <= 1'b1;
                        ram_dout_q <= mem_wdata[7:0];
                     end else begin
                        state_q <= MEM_RD;
                     end
                  end else if (if_req) begin
                     addr_q  <= if_addr;
                     last_q  <= 2'd3;
                     len_q   <= LEN_WORD;
                     sgn_q   <= 1'b0;
                     ram_a_q <= if_addr;
                     state_q <= IF_RD;
                  end
               end
            end
            IF_RD, MEM_RD: begin
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q != 3'd0)
                  buf_q <= ins_d;
               if (cnt_q < {1'b0, last_q})
                  ram_a_q <= addr_q + 32'(cnt_q) + 32'd1;
               else
                  ram_a_q <= '0;
               if (cnt_q == {1'b0, last_q} + 3'd1) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  if (state_q == IF_RD) begin
                     if_done_q <= 1'b1;
                     if_inst_q <= ext_d;
                  end else begin
                     mem_done_q  <= 1'b1;
                     mem_rdata_q <= ext_d;
                  end
               end
            end
            MEM_WR: begin
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q < {1'b0, last_q}) begin
                  ram_a_q    <= addr_q + 32'(cnt_q) + 32'd1;
                  ram_dout_q <= wdata_q[{wr_idx_d, 3'b000} +: RAM_DW];
               end else begin
                  ram_a_q    <= '0;
                  ram_dout_q <= '0;
                  ram_wr_q   <= 1'b0;
                  mem_done_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ram_a        = ram_a_q;
   assign ram_dout     = ram_dout_q;
   assign ram_wr       = ram_wr_q;
   assign if_done      = if_done_q;
   assign if_inst      = if_inst_q;
   assign mem_done     = mem_done_q;
   assign mem_rdata    = mem_rdata_q;
   assign stallreq_if  = if_req & ~if_done_q;
   assign stallreq_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a one-cycle-latency byte RAM model.
// Expected load results follow MEMCTRL_SEXT_EN when the bench is built with it.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [1:0]  mem_len = '0;
   logic        mem_signed = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [31:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic [7:0]  ram_din = '0;
   logic        stallreq_if;
   logic        stallreq_mem;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   logic [7:0] ram_init [4096];
   logic [7:0] ram_wrd  [4096];
   bit         wflag    [4096];

   mem_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_done      (if_done),
      .if_inst      (if_inst),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_len      (mem_len),
      .mem_signed   (mem_signed),
      .mem_wdata    (mem_wdata),
      .mem_done     (mem_done),
      .mem_rdata    (mem_rdata),
      .ram_a        (ram_a),
      .ram_dout     (ram_dout),
      .ram_wr       (ram_wr),
      .ram_din      (ram_din),
      .stallreq_if  (stallreq_if),
      .stallreq_mem (stallreq_mem)
   );

   always #5 clk = ~clk;

   // RAM model: registered read, write on rising edge; the low 12 address bits select the entry.
   always @(posedge clk) begin
      if (ram_wr) begin
         ram_wrd[ram_a[11:0]] <= ram_dout;
         wflag[ram_a[11:0]]   <= 1'b1;
      end
      ram_din <= wflag[ram_a[11:0]] ? ram_wrd[ram_a[11:0]] : ram_init[ram_a[11:0]];
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end of the sequence");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one load, returns mem_done and mem_rdata as seen in cycle N+1 after the grant.
   task automatic run_load(input logic [31:0] a, input logic [1:0] len, input logic sgn,
                           output logic done_o, output logic [31:0] data_o);
      int unsigned n;
      n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = a; mem_len = len; mem_signed = sgn;
      tick();
      repeat (n + 1) tick();
      done_o = mem_done;
      data_o = mem_rdata;
      mem_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #12;
      n_assert++; if (ram_a !== 32'h0) begin n_fail++; $display("FAIL reset_ram_a: got %h want 00000000", ram_a); end
      n_assert++; if (ram_wr !== 1'b0 || ram_dout !== 8'h00) begin n_fail++; $display("FAIL reset_ram_wr_dout: got %b/%h want 0/00", ram_wr, ram_dout); end
      n_assert++; if (if_done !== 1'b0 || mem_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b/%b want 0/0", if_done, mem_done); end
      n_assert++; if (if_inst !== 32'h0 || mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", if_inst, mem_rdata); end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_if_read();
      ram_init[12'h000] = 8'h13; ram_init[12'h001] = 8'h00;
      ram_init[12'h002] = 8'h00; ram_init[12'h003] = 8'h93;
      if_req = 1'b1; if_addr = 32'h0000_1000;
      tick();
      for (int k = 0; k < 4; k++) begin
         n_assert++; if (ram_a !== 32'h0000_1000 + k || ram_wr !== 1'b0) begin n_fail++; $display("FAIL if_addr[%0d]: got %h/%b want %h/0", k, ram_a, ram_wr, 32'h0000_1000 + k); end
         if (k == 0) begin
            if_addr = 32'h0000_0BAD;
            n_assert++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL if_stall: got %b want 1", stallreq_if); end
         end
         tick();
      end
      n_assert++; if (if_done !== 1'b0 || ram_a !== 32'h0) begin n_fail++; $display("FAIL if_cycle4: got done %b a %h want 0 00000000", if_done, ram_a); end
      tick();
      n_assert++; if (if_done !== 1'b1 || stallreq_if !== 1'b0) begin n_fail++; $display("FAIL if_done_c5: got %b stall %b want 1 0", if_done, stallreq_if); end
      n_assert++; if (if_inst !== 32'h9300_0013) begin n_fail++; $display("FAIL if_inst: got %h want 93000013", if_inst); end
      if_req = 1'b0;
      tick();
      n_assert++; if (if_done !== 1'b0 || if_inst !== 32'h9300_0013) begin n_fail++; $display("FAIL if_hold: got %b %h want 0 93000013", if_done, if_inst); end
   endtask

   task automatic test_store();
      logic [7:0]  exp_b [4];
      logic        d;
      logic [31:0] r;
      exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_len = 2'b10; mem_wdata = 32'hDEAD_BEEF;
      tick();
      for (int k = 0; k < 4; k++) begin
         n_assert++; if (ram_wr !== 1'b1 || ram_a !== 32'h20 + k || ram_dout !== exp_b[k] || mem_done !== 1'b0) begin
            n_fail++; $display("FAIL st_byte[%0d]: got wr %b a %h d %h done %b want 1 %h %h 0", k, ram_wr, ram_a, ram_dout, mem_done, 32'h20 + k, exp_b[k]); end
         if (k == 0) mem_wdata = 32'h0;
         tick();
      end
      n_assert++; if (mem_done !== 1'b1 || ram_wr !== 1'b0 || ram_a !== 32'h0) begin n_fail++; $display("FAIL st_done_c4: got done %b wr %b a %h want 1 0 00000000", mem_done, ram_wr, ram_a); end
      mem_req = 1'b0; mem_we = 1'b0;
      tick();
      run_load(32'h20, 2'b10, 1'b0, d, r);
      n_assert++; if (d !== 1'b1 || r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_readback: got done %b data %h want 1 deadbeef", d, r); end
   endtask

   task automatic test_priority();
      ram_init[12'h200] = 8'h5A;
      ram_init[12'h300] = 8'h01; ram_init[12'h301] = 8'h02;
      ram_init[12'h302] = 8'h03; ram_init[12'h303] = 8'h04;
      if_req = 1'b1; if_addr = 32'h300;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_len = 2'b00; mem_signed = 1'b0;
      tick();
      n_assert++; if (ram_a !== 32'h200 || stallreq_if !== 1'b1 || stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL prio_grant: got a %h si %b sm %b want 00000200 1 1", ram_a, stallreq_if, stallreq_mem); end
      tick();
      tick();
      n_assert++; if (mem_done !== 1'b1 || mem_rdata !== 32'h5A || stallreq_mem !== 1'b0) begin n_fail++; $display("FAIL prio_mem_done: got %b %h sm %b want 1 0000005a 0", mem_done, mem_rdata, stallreq_mem); end
      mem_req = 1'b0;
      tick();
      n_assert++; if (ram_a !== 32'h0 || if_done !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap: got a %h done %b want 00000000 0", ram_a, if_done); end
      tick();
      n_assert++; if (ram_a !== 32'h300) begin n_fail++; $display("FAIL prio_if_grant: got %h want 00000300", ram_a); end
      repeat (5) tick();
      n_assert++; if (if_done !== 1'b1 || if_inst !== 32'h0403_0201) begin n_fail++; $display("FAIL prio_if_done: got %b %h want 1 04030201", if_done, if_inst); end
      n_assert++; if (mem_rdata !== 32'h5A) begin n_fail++; $display("FAIL prio_rdata_hold: got %h want 0000005a", mem_rdata); end
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_sign_ext();
      logic        d;
      logic [31:0] r;
      logic [31:0] exp_sb;
      logic [31:0] exp_sh;
`ifdef MEMCTRL_SEXT_EN
      exp_sb = 32'hFFFF_FF80; exp_sh = 32'hFFFF_8001;
`else
      exp_sb = 32'h0000_0080; exp_sh = 32'h0000_8001;
`endif
      ram_init[12'h500] = 8'h80;
      ram_init[12'h502] = 8'h01; ram_init[12'h503] = 8'h80;
      run_load(32'h500, 2'b00, 1'b1, d, r);
      n_assert++; if (d !== 1'b1 || r !== exp_sb) begin n_fail++; $display("FAIL sext_byte: got %b %h want 1 %h", d, r, exp_sb); end
      run_load(32'h500, 2'b00, 1'b0, d, r);
      n_assert++; if (d !== 1'b1 || r !== 32'h80) begin n_fail++; $display("FAIL zext_byte: got %b %h want 1 00000080", d, r); end
      run_load(32'h502, 2'b01, 1'b1, d, r);
      n_assert++; if (d !== 1'b1 || r !== exp_sh) begin n_fail++; $display("FAIL sext_half: got %b %h want 1 %h", d, r, exp_sh); end
   endtask

   task automatic test_wrap();
      ram_init[12'hFFF] = 8'h34; ram_init[12'h000] = 8'h12;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'hFFFF_FFFF; mem_len = 2'b01; mem_signed = 1'b0;
      tick();
      mem_addr = 32'h0000_0700; mem_len = 2'b10;
      n_assert++; if (ram_a !== 32'hFFFF_FFFF || stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL wrap_c0: got %h sm %b want ffffffff 1", ram_a, stallreq_mem); end
      tick();
      n_assert++; if (ram_a !== 32'h0 || stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL wrap_c1: got %h sm %b want 00000000 1", ram_a, stallreq_mem); end
      tick();
      n_assert++; if (mem_done !== 1'b0 || stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL wrap_c2: got done %b sm %b want 0 1", mem_done, stallreq_mem); end
      tick();
      n_assert++; if (mem_done !== 1'b1 || mem_rdata !== 32'h1234 || stallreq_mem !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got %b %h sm %b want 1 00001234 0", mem_done, mem_rdata, stallreq_mem); end
      mem_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_write();
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_len = 2'b10; mem_wdata = 32'h1122_3344;
      tick();
      tick();
      tick();
      n_assert++; if (ram_wr !== 1'b1 || ram_a !== 32'h42) begin n_fail++; $display("FAIL rst_pre: got wr %b a %h want 1 00000042", ram_wr, ram_a); end
      #1 rst = 1'b0;
      #1;
      n_assert++; if (ram_wr !== 1'b0 || ram_a !== 32'h0 || mem_done !== 1'b0 || mem_rdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_abort: got wr %b a %h done %b rd %h want 0 0 0 0", ram_wr, ram_a, mem_done, mem_rdata); end
      mem_req = 1'b0; mem_we = 1'b0;
      tick();
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_assert++; if (mem_done !== 1'b0 || ram_wr !== 1'b0 || ram_a !== 32'h0) begin n_fail++; $display("FAIL rst_post[%0d]: got done %b wr %b a %h want 0 0 0", k, mem_done, ram_wr, ram_a); end
      end
      n_assert++; if (ram_wrd[12'h040] !== 8'h44 || ram_wrd[12'h041] !== 8'h33 || wflag[12'h042] !== 1'b0 || wflag[12'h043] !== 1'b0) begin
         n_fail++; $display("FAIL rst_partial: got %h %h flags %b%b want 44 33 00", ram_wrd[12'h040], ram_wrd[12'h041], wflag[12'h042], wflag[12'h043]); end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_store();
      test_priority();
      test_sign_ext();
      test_wrap();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports if_req in 1, if_addr in 32; instruction-fetch request, level held until if_done.
REQ-004 SHALL have ports if_done out 1, if_inst out 32; one-cycle completion pulse plus fetched word.
REQ-005 SHALL have ports mem_req in 1, mem_we in 1, mem_addr in 32, mem_len in 2, mem_signed in 1, mem_wdata in 32; load/store request.
REQ-006 SHALL have ports mem_done out 1, mem_rdata out 32; one-cycle completion pulse plus load result.
REQ-007 SHALL have ports ram_a out 32, ram_dout out 8, ram_wr out 1, ram_din in 8; byte-wide RAM port.
REQ-008 SHALL have ports stallreq_if out 1, stallreq_mem out 1; stall requests to the pipeline controller.

Function
REQ-009 SHALL implement FSM states IDLE, IF_RD, MEM_RD, MEM_WR.
REQ-010 IDLE: mem_req has priority; mem_req & mem_we -> MEM_WR, mem_req & !mem_we -> MEM_RD, else if_req -> IF_RD, else stay IDLE.
REQ-011 Grant edge SHALL latch address, length, signedness and write data; later request-input changes are ignored until done.
REQ-012 Length N: mem_len 00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes; IF always 4 bytes.
REQ-013 Read: cycles k = 0..N-1 after grant drive ram_a = addr+k, ram_wr = 0; ram_din sampled at the edge ending cycle k+1 into little-endian byte lane k.
REQ-014 Read done (if_done or mem_done) SHALL be registered high during cycle N+1, with if_inst/mem_rdata valid in that cycle and held until the next grant of that requester.
REQ-015 Write: cycles k = 0..N-1 drive ram_a = addr+k, ram_dout = wdata byte k, ram_wr = 1; mem_done high during cycle N with ram_wr = 0.
REQ-016 Done cycle SHALL return the FSM to IDLE; the requester drops req on the edge that samples done; no back-to-back grant without one IDLE cycle.
REQ-017 Address arithmetic SHALL be 32-bit modulo; 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-018 stallreq_mem SHALL equal mem_req & !mem_done; stallreq_if SHALL equal if_req & !if_done (combinational).
REQ-019 Unused upper bytes of mem_rdata for N < 4 SHALL follow REQ-024/REQ-025.
REQ-020 Outside read/write cycles, ram_wr SHALL be 0 and ram_a SHALL be 0.

Reset
REQ-021 rst low SHALL asynchronously force IDLE, ram_wr = 0, ram_a = 0, ram_dout = 0, if_done = 0, mem_done = 0, if_inst = 0, mem_rdata = 0, byte counter = 0.
REQ-022 Reset mid-transaction SHALL abort it with no done pulse; partial writes already issued are not undone.
REQ-023 Operation SHALL resume with IDLE arbitration at the first rising edge after rst deasserts.

Configuration
REQ-024 With MEMCTRL_SEXT_EN defined: when mem_signed = 1, 1- and 2-byte loads SHALL be sign-extended from bit 7/15; mem_signed = 0 zero-extends.
REQ-025 Without MEMCTRL_SEXT_EN: all loads SHALL be zero-extended, and mem_signed SHALL be ignored.

Structure
REQ-026 FSM state encodings, mem_len codes and the RAM port width SHALL live in the shared defines header alongside the existing bus-width macros.
REQ-027 Byte assembly/extension SHALL be a sub-module mem_ctrl_bytepack (lane insert plus extend).

Verification
REQ-028 Reset pulse mid-MEM_WR after 2 of 4 bytes -> ram_wr = 0 immediately, no mem_done, IDLE after release.
REQ-029 IF read 0x00001000, RAM bytes 13 00 00 93 -> ram_a 0x1000..0x1003, if_done in cycle 5, if_inst = 0x93000013.
REQ-030 if_req and mem_req (load) both high in IDLE -> MEM_RD granted first; IF_RD granted after mem_done plus one IDLE cycle.
REQ-031 Store word 0xDEADBEEF at 0x20 -> ram_wr high for 4 cycles, ram_dout EF BE AD DE, mem_done in cycle 4.
REQ-032 Signed byte load of 0x80 (mem_signed = 1) -> mem_rdata 0xFFFFFF80 with MEMCTRL_SEXT_EN, 0x00000080 without it.
REQ-033 Halfword read at 0xFFFFFFFF -> ram_a 0xFFFFFFFF then 0x00000000; stallreq_mem high until mem_done.
